// File: rtl/bcd_counter_0_9999_pkg.sv
// Package: bcd_pkg
// Constants and helpers shared by the four-decade BCD counter, its digit
// stage and its interface.
//   DIG_W      width of one BCD digit
//   BCD_MAX    largest legal digit value (9)
//   BCD_MIN    smallest legal digit value (0)
//   bcd_clamp  saturates a nibble to the legal BCD range
package bcd_pkg;

    localparam int unsigned DIG_W = 4;

    localparam logic [DIG_W-1:0] BCD_MAX = 4'd9;
    localparam logic [DIG_W-1:0] BCD_MIN = 4'd0;

    function automatic logic [DIG_W-1:0] bcd_clamp(input logic [DIG_W-1:0] n);
        return (n > BCD_MAX) ? BCD_MAX : n;
    endfunction

endpackage

// File: rtl/bcd_counter_0_9999_if.sv
// Interface: bcd_counter_0_9999_if
// Control inputs and display outputs of the BCD counter.
//   en, up, clr, load, load_val   control (driven by master)
//   thou, hund, tens, units       BCD digits, most significant first (driven by slave)
//   tick, wrap                    one-cycle step / wrap-around pulses (driven by slave)
interface bcd_counter_0_9999_if;
    import bcd_pkg::*;

    logic             en;
    logic             up;
    logic             clr;
    logic             load;
    logic [15:0]      load_val;
    logic [DIG_W-1:0] thou;
    logic [DIG_W-1:0] hund;
    logic [DIG_W-1:0] tens;
    logic [DIG_W-1:0] units;
    logic             tick;
    logic             wrap;

    modport master (
        output en, up, clr, load, load_val,
        input  thou, hund, tens, units, tick, wrap
    );

    modport slave (
        input  en, up, clr, load, load_val,
        output thou, hund, tens, units, tick, wrap
    );

endinterface

// File: rtl/bcd_counter_0_9999_digit.sv
// Module: bcd_digit
// One BCD decade with ripple carry/borrow for chaining.
//   clk, rst_n   clock, asynchronous active-low reset
//   inc, dec     step this digit up / down (from the previous stage's co/bo)
//   clr          synchronous clear to 0 (highest priority)
//   ld, ld_val   synchronous load; values above 9 are saturated to 9
//   q            registered digit, always 0..9
//   co, bo       carry out (inc at 9) / borrow out (dec at 0), combinational
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    input  logic             ld,
    input  logic [DIG_W-1:0] ld_val,
    output logic [DIG_W-1:0] q,
    output logic             co,
    output logic             bo
);

    assign co = inc & (q == BCD_MAX);
    assign bo = dec & (q == BCD_MIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (ld) begin
            q <= bcd_clamp(ld_val);
        end else if (inc) begin
            q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
        end else if (dec) begin
            q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_counter_0_9999.sv
// Module: bcd_counter_0_9999
// Four-decade BCD up/down counter (0000..9999) with a built-in tick prescaler.
// Steps once every TICK_DIV enabled clocks; feeds a multiplexed 7-segment driver.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  en/up/clr/load/load_val in; thou/hund/tens/units/tick/wrap out
// Priority per cycle: clr > load > step > hold. All outputs are registered.
module bcd_counter_0_9999
    import bcd_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned TICK_W   = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_counter_0_9999_if.slave bus
);

    localparam logic [TICK_W-1:0] PRESC_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] presc;
    logic              step;
    logic              co_u, co_t, co_h, co_th;
    logic              bo_u, bo_t, bo_h, bo_th;

    // clr/load suppress the step so a colliding period end is discarded.
    assign step = bus.en & (presc == PRESC_LAST) & ~bus.clr & ~bus.load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            bus.tick <= 1'b0;
            bus.wrap <= 1'b0;
        end else begin
            bus.tick <= step;
            bus.wrap <= co_th | bo_th;
            if (bus.clr || bus.load) begin
                presc <= '0;
            end else if (bus.en) begin
                presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
            end
        end
    end

    bcd_digit u_units (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (step & bus.up),
        .dec    (step & ~bus.up),
        .clr    (bus.clr),
        .ld     (bus.load),
        .ld_val (bus.load_val[3:0]),
        .q      (bus.units),
        .co     (co_u),
        .bo     (bo_u)
    );

    bcd_digit u_tens (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (co_u),
        .dec    (bo_u),
        .clr    (bus.clr),
        .ld     (bus.load),
        .ld_val (bus.load_val[7:4]),
        .q      (bus.tens),
        .co     (co_t),
        .bo     (bo_t)
    );

    bcd_digit u_hund (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (co_t),
        .dec    (bo_t),
        .clr    (bus.clr),
        .ld     (bus.load),
        .ld_val (bus.load_val[11:8]),
        .q      (bus.hund),
        .co     (co_h),
        .bo     (bo_h)
    );

    bcd_digit u_thou (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (co_h),
        .dec    (bo_h),
        .clr    (bus.clr),
        .ld     (bus.load),
        .ld_val (bus.load_val[15:12]),
        .q      (bus.thou),
        .co     (co_th),
        .bo     (bo_th)
    );

endmodule

// File: tb/tb_bcd_counter_0_9999.sv
// Testbench: tb_bcd_counter_0_9999
// Checks the BCD counter (TICK_DIV=4 and TICK_DIV=1 instances) against an
// integer reference model plus hand-written corner-case sequences.
module tb_bcd_counter_0_9999;

    localparam int TDIV = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bcd_counter_0_9999_if i0 ();
    bcd_counter_0_9999_if i1 ();

    bcd_counter_0_9999 #(.TICK_DIV(TDIV), .TICK_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i0)
    );

    bcd_counter_0_9999 #(.TICK_DIV(1), .TICK_W(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i1)
    );

    logic [15:0] dig0, dig1;
    assign dig0 = {i0.thou, i0.hund, i0.tens, i0.units};
    assign dig1 = {i1.thou, i1.hund, i1.tens, i1.units};

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: counter value as a plain integer 0..9999.
    int m_val   = 0;
    int m_presc = 0;
    bit m_tick  = 0;
    bit m_wrap  = 0;

    typedef struct {
        logic        clr;
        logic        load;
        logic        en;
        logic        up;
        logic [15:0] load_val;
        logic [15:0] exp_digits;
        string       name;
    } vec_t;

    vec_t vt[7];

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int load_value(input logic [15:0] lv);
        int r = 0;
        for (int k = 3; k >= 0; k--) begin
            int n = int'((lv >> (4 * k)) & 16'hF);
            if (n > 9) n = 9;
            r = r * 10 + n;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        m_tick = 0;
        m_wrap = 0;
        if (i0.clr) begin
            m_val = 0;
            m_presc = 0;
        end else if (i0.load) begin
            m_val = load_value(i0.load_val);
            m_presc = 0;
        end else if (i0.en) begin
            if (m_presc == TDIV - 1) begin
                m_presc = 0;
                m_tick = 1;
                if (i0.up) begin
                    m_wrap = (m_val == 9999);
                    m_val = (m_val + 1) % 10000;
                end else begin
                    m_wrap = (m_val == 0);
                    m_val = (m_val + 9999) % 10000;
                end
            end else begin
                m_presc++;
            end
        end
    endtask

    // One clock: model follows the inputs present at the edge, then outputs are compared.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("model_digits", dig0, to_bcd(m_val));
        chk("model_tick", {15'd0, i0.tick}, {15'd0, m_tick});
        chk("model_wrap", {15'd0, i0.wrap}, {15'd0, m_wrap});
    endtask

    task automatic drive(input logic en, input logic up, input logic clr,
                         input logic load, input logic [15:0] lv);
        i0.en = en;
        i0.up = up;
        i0.clr = clr;
        i0.load = load;
        i0.load_val = lv;
    endtask

    initial begin
        int ticks;
        int wraps;

        vt[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h9998, 16'h9998, "tbl_load_9998"};
        vt[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'hFA3C, 16'h9939, "tbl_load_FA3C"};
        vt[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h1234, "tbl_load_1234"};
        vt[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h7777, 16'h0000, "tbl_clr"};
        vt[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h5678, 16'h0000, "tbl_clr_beats_load"};
        vt[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0A0B, 16'h0909, "tbl_load_0A0B"};
        vt[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h5000, 16'h5000, "tbl_load_5000"};

        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        i1.en = 1'b0;
        i1.up = 1'b1;
        i1.clr = 1'b0;
        i1.load = 1'b0;
        i1.load_val = 16'h0000;
        #1;
        chk("reset_digits", dig0, 16'h0000);
        chk("reset_tick", {15'd0, i0.tick}, 16'h0000);
        chk("reset_wrap", {15'd0, i0.wrap}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Up count from 0000 for 40 cycles.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (i0.tick) ticks++;
        end
        chk("up40_digits", dig0, 16'h0010);
        chk("up40_ticks", 16'(ticks), 16'd10);
        chk("up40_tick_now", {15'd0, i0.tick}, 16'h0001);

        // Async reset between edges while tick is high.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_digits", dig0, 16'h0000);
        chk("async_rst_tick", {15'd0, i0.tick}, 16'h0000);
        m_val = 0;
        m_presc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        // Partial prescaler progress must be gone: first step after 4 cycles.
        for (int i = 0; i < 3; i++) cycle();
        chk("post_rst_no_step", dig0, 16'h0000);
        cycle();
        chk("post_rst_step", dig0, 16'h0001);

        // Load 9998 then up-wrap.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h9998);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 4; i++) cycle();
        chk("upwrap_9999", dig0, 16'h9999);
        chk("upwrap_9999_wrap", {15'd0, i0.wrap}, 16'h0000);
        for (int i = 0; i < 4; i++) cycle();
        chk("upwrap_0000", dig0, 16'h0000);
        chk("upwrap_tick", {15'd0, i0.tick}, 16'h0001);
        chk("upwrap_wrap", {15'd0, i0.wrap}, 16'h0001);
        cycle();
        chk("upwrap_wrap_gone", {15'd0, i0.wrap}, 16'h0000);

        // Load 0001 then down-wrap.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0001);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 4; i++) cycle();
        chk("dnwrap_0000", dig0, 16'h0000);
        chk("dnwrap_0000_wrap", {15'd0, i0.wrap}, 16'h0000);
        for (int i = 0; i < 4; i++) cycle();
        chk("dnwrap_9999", dig0, 16'h9999);
        chk("dnwrap_wrap", {15'd0, i0.wrap}, 16'h0001);

        // Freeze mid-period, then resume with the remaining count.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h4321);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        cycle();
        cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 10; i++) cycle();
        chk("freeze_digits", dig0, 16'h4321);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        cycle();
        chk("resume_no_step", dig0, 16'h4321);
        cycle();
        chk("resume_step", dig0, 16'h4322);
        chk("resume_tick", {15'd0, i0.tick}, 16'h0001);

        // clr on the cycle that would otherwise step.
        for (int i = 0; i < 3; i++) cycle();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        cycle();
        chk("clr_on_step_digits", dig0, 16'h0000);
        chk("clr_on_step_tick", {15'd0, i0.tick}, 16'h0000);

        // Table of single-cycle clr/load vectors.
        for (int v = 0; v < 7; v++) begin
            drive(vt[v].en, vt[v].up, vt[v].clr, vt[v].load, vt[v].load_val);
            cycle();
            chk(vt[v].name, dig0, vt[v].exp_digits);
            chk({vt[v].name, "_tick"}, {14'd0, i0.tick, i0.wrap}, 16'h0000);
        end

        // Randomized stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 8) != 0, 1'($urandom % 2), ($urandom % 64) == 0,
                  ($urandom % 50) == 0, 16'($urandom));
            cycle();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

        // TICK_DIV=1: increments every enabled cycle, one wrap in 10000 steps.
        i1.clr = 1'b1;
        @(posedge clk);
        #1;
        chk("div1_clr", dig1, 16'h0000);
        i1.clr = 1'b0;
        i1.en = 1'b1;
        i1.up = 1'b1;
        ticks = 0;
        wraps = 0;
        for (int i = 1; i <= 10000; i++) begin
            @(posedge clk);
            #1;
            if (i1.tick) ticks++;
            if (i1.wrap) wraps++;
            if (i == 1) chk("div1_first", dig1, 16'h0001);
            if (i == 9999) chk("div1_9999", dig1, 16'h9999);
            if (i == 10000) chk("div1_wrap_pulse", {15'd0, i1.wrap}, 16'h0001);
        end
        chk("div1_final", dig1, 16'h0000);
        chk("div1_ticks", 16'(ticks), 16'd10000);
        chk("div1_wraps", 16'(wraps), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
